// File: rtl/sbus2apb_bridge.sv
// Simple request/response bus to APB3 master bridge with incrementing read bursts.
// Optional APB access watchdog enabled by defining SBUS2APB_TIMEOUT_EN.
module sbus2apb_bridge #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [2:0]  PROT        = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [3:0]  req_len,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        resp_last,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  output logic [1:0]  o_dbg_state
);

  // Request: accepted on req_valid && req_ready. Response: beat consumed on
  // resp_valid && resp_ready; resp_* hold stable until then.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_tmo;
  logic        w_unused;

  assign w_unused = ^{req_addr[1:0], (TIMEOUT_CYC == 0)};

`ifdef SBUS2APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;

  assign w_tmo = (r_state == S_ACCESS) && !out_pready &&
                 (r_tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   r_tcnt <= '0;
    else if (r_state == S_SETUP)   r_tcnt <= '0;
    else if (r_state == S_ACCESS)  r_tcnt <= r_tcnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (out_pready || w_tmo) w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = (r_cnt == 4'd0) ? S_IDLE : S_SETUP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= {req_addr[31:2], 2'b00};
          r_write <= req_write;
          r_wdata <= req_wdata;
          r_wstrb <= req_wstrb;
          r_cnt   <= req_write ? 4'd0 : req_len;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        S_ACCESS: begin
          if (out_pready) begin
            r_rdata <= r_write ? 32'h0 : out_prdata;
            r_err   <= out_pslverr;
          end else if (w_tmo) begin
            r_rdata <= 32'hDEAD_BEEF;
            r_err   <= 1'b1;
          end
        end
        S_RESP: if (resp_ready && (r_cnt != 4'd0)) begin
          // Next burst beat: wraps modulo 2^32 with no page check.
          r_cnt  <= r_cnt - 4'd1;
          r_addr <= r_addr + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // req_ready is gated by resetn so it reads 0 for the whole reset pulse.
  assign req_ready   = (r_state == S_IDLE) && resetn;
  assign out_psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign out_penable = (r_state == S_ACCESS);
  assign out_pprot   = PROT;
  assign out_paddr   = r_addr;
  assign out_pwrite  = r_write;
  assign out_pwdata  = r_wdata;
  assign out_pstrb   = r_write ? r_wstrb : 4'h0;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_last   = (r_state == S_RESP) && (r_cnt == 4'd0);
  assign resp_data   = r_rdata;
  assign resp_err    = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sbus2apb_bridge.sv
// Scoreboarded bench for sbus2apb_bridge: random requests, APB slave model with
// random waits, response backpressure, burst timing, async reset and timeout.
module tb_sbus2apb_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [3:0]  req_len = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        resp_last;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  sbus2apb_bridge #(.TIMEOUT_CYC(8), .PROT(3'b000)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .resp_last(resp_last),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr), .o_dbg_state(dbg_state)
  );

  // Scoreboard state: exp_q holds {last, err, data}; apb_q holds {write, strb, addr, wdata}.
  logic [33:0] exp_q[$];
  logic [68:0] apb_q[$];
  logic [31:0] rd_mem[logic [31:0]];
  int n_checks = 0;
  int n_pass   = 0;

  int fixed_wait = 0;
  bit rr_rand    = 1'b0;
  int rr_hold    = 0;
  bit tmo_mode   = 1'b0;
  int wcnt       = 0;
  int cyc        = 0;
  int pen_cnt    = 0;
  int setup_cnt  = 0;
  int stall_cnt  = 0;
  bit tm_arm     = 1'b0;
  int tm_first   = -1;
  int tm_last    = -1;
  bit prev_stall = 1'b0;
  bit prev_wait  = 1'b0;
  logic [34:0] hold_resp;
  logic [33:0] hold_apb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Peripheral contents: a fixed function of the word address unless preset.
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    if (rd_mem.exists(a)) return rd_mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'hC3A5_0F96;
  endfunction

  function automatic logic slave_err(input logic [31:0] a);
    return a[4:2] == 3'b101;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // APB slave, response consumer and monitor share the falling edge.
  always @(negedge clk) begin
    if (out_psel && !out_penable) begin
      wcnt = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
      out_pready = 1'b0;
    end else if (out_psel && out_penable && wcnt == 0) begin
      out_pready  = 1'b1;
      out_prdata  = slave_rd(out_paddr);
      out_pslverr = slave_err(out_paddr);
    end else begin
      if (out_psel && out_penable) wcnt--;
      out_pready  = 1'b0;
      out_prdata  = $urandom;
      out_pslverr = 1'($urandom_range(0, 1));
    end

    if (rr_hold > 0 && resp_valid) begin
      resp_ready = 1'b0;
      rr_hold--;
    end else if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
    else resp_ready = 1'b1;

    if (!resetn) begin
      prev_stall = 1'b0;
      prev_wait  = 1'b0;
    end else begin
      if (out_penable) pen_cnt++;
      if (out_psel && !out_penable) begin
        setup_cnt++;
        if (tm_arm && tm_first < 0) tm_first = cyc;
      end
      if (prev_wait && !tmo_mode)
        check("apb_hold", 64'({out_psel, out_penable, out_paddr}), 64'(hold_apb));
      if (out_psel && out_penable && out_pready) begin
        if (apb_q.size() == 0) check("apb_unexpected", 64'(apb_q.size()), 64'd1);
        else begin
          logic [68:0] e;
          e = apb_q.pop_front();
          check("paddr", 64'(out_paddr), 64'(e[63:32]));
          check("pwrite", 64'(out_pwrite), 64'(e[68]));
          check("pstrb", 64'(out_pstrb), 64'(e[67:64]));
          check("pprot", 64'(out_pprot), 64'd0);
          if (e[68]) check("pwdata", 64'(out_pwdata), 64'(e[31:0]));
        end
      end
      prev_wait = out_psel && out_penable && !out_pready;
      hold_apb  = {out_psel, out_penable, out_paddr};

      if (prev_stall) begin
        stall_cnt++;
        check("resp_stable", 64'({resp_valid, resp_last, resp_err, resp_data}), 64'(hold_resp));
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", 64'(exp_q.size()), 64'd1);
        else begin
          logic [33:0] r;
          r = exp_q.pop_front();
          check("resp_data", 64'(resp_data), 64'(r[31:0]));
          check("resp_err", 64'(resp_err), 64'(r[32]));
          check("resp_last", 64'(resp_last), 64'(r[33]));
        end
        if (tm_arm && resp_last) tm_last = cyc;
      end
      prev_stall = resp_valid && !resp_ready;
      hold_resp  = {resp_valid, resp_last, resp_err, resp_data};
    end
  end

  // Drive one request and record what the bridge must do with it.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [3:0] len);
    int n;
    int beats;
    logic [31:0] a;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    req_wdata = wd; req_wstrb = ws; req_len = len;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    if (req_ready) begin
      beats = wr ? 1 : int'(len) + 1;
      for (int i = 0; i < beats; i++) begin
        a = {addr[31:2], 2'b00} + 32'(4 * i);
        if (tmo_mode) exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
        else begin
          exp_q.push_back({i == beats - 1, slave_err(a), wr ? 32'h0 : slave_rd(a)});
          apb_q.push_back({wr, wr ? ws : 4'h0, a, wd});
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || apb_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size() + apb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    #1 resetn = 1'b0;
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_apb", 64'({out_psel, out_penable, out_paddr, out_pstrb}), 64'd0);
    check("rst_resp", 64'({resp_valid, resp_last, resp_err, resp_data}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1 check("rel_req_ready", 64'(req_ready), 64'd1);

    // Single read, two wait states.
    fixed_wait = 2; rr_rand = 1'b0;
    rd_mem[32'h3000_0004] = 32'h1234_5678;
    pen_cnt = 0; setup_cnt = 0;
    issue(32'h3000_0004, 1'b0, 32'h0, 4'h0, 4'd0);
    drain();
    check("single_penable_cycles", 64'(pen_cnt), 64'd3);
    check("single_setup_cycles", 64'(setup_cnt), 64'd1);

    // Four-beat burst, zero waits: SETUP of beat 1 to last RESP is 12 cycles.
    fixed_wait = 0; tm_arm = 1'b1; tm_first = -1; tm_last = -1;
    issue(32'h3000_0010, 1'b0, 32'h0, 4'h0, 4'd3);
    drain();
    tm_arm = 1'b0;
    check("burst_cycles", 64'(tm_last - tm_first + 1), 64'd12);

    // Write: unaligned address, single strobe.
    issue(32'h1000_0003, 1'b1, 32'hA5A5_A5A5, 4'b0010, 4'd5);
    drain();

    // Error on first beat, response held off for 5 cycles.
    stall_cnt = 0; rr_hold = 5;
    issue(32'h2000_0014, 1'b0, 32'h0, 4'h0, 4'd1);
    drain();
    check("stall_cycles", 64'(stall_cnt), 64'd5);

    // Burst across the top of the address space.
    fixed_wait = 1;
    issue(32'hFFFF_FFF9, 1'b0, 32'h0, 4'h0, 4'd3);
    drain();

    // Randomized traffic with random waits and backpressure.
    fixed_wait = -1; rr_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : $urandom;
      issue(a, ($urandom_range(0, 2) == 0), $urandom, 4'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Asynchronous reset in the middle of a burst access.
    fixed_wait = 3; rr_rand = 1'b0;
    issue(32'h4000_0000, 1'b0, 32'h0, 4'h0, 4'd7);
    n = 0;
    while (!(out_psel && out_penable) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 resetn = 1'b0;
    #1;
    check("arst_psel_penable", 64'({out_psel, out_penable}), 64'd0);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    apb_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1 check("arst_rel_req_ready", 64'(req_ready), 64'd1);
    fixed_wait = 0;
    issue(32'h4000_0100, 1'b0, 32'h0, 4'h0, 4'd1);
    drain();

`ifdef SBUS2APB_TIMEOUT_EN
    // Slave never answers: watchdog ends the access after 8 cycles.
    fixed_wait = 100000; tmo_mode = 1'b1; pen_cnt = 0;
    issue(32'h5000_0000, 1'b0, 32'h0, 4'h0, 4'd0);
    drain();
    check("tmo_access_cycles", 64'(pen_cnt), 64'd8);
    tmo_mode = 1'b0; fixed_wait = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/sbus2apb_bridge.md
# sbus2apb_bridge

Converts the core's simple request/response memory bus into APB3 master transfers toward the peripheral fabric, including the SPI flash bridge, which it feeds directly. Reads support bursts of up to 16 words, split into back-to-back APB word reads with incrementing addresses, for cache-line refill from flash. Writes are single-beat. One request is outstanding at a time; APB errors are reported per beat.

## Interface
- `TIMEOUT_CYC`, 4096: APB access-phase watchdog limit in cycles; used only with the timeout feature.
- `PROT`, 3'b000: constant driven on `out_pprot`.
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in 32: byte address; bits [1:0] are ignored and the address is word-aligned.
- `req_write` in 1: 1 = write, 0 = read.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: write byte strobes.
- `req_len` in 4: burst beats minus 1 for reads; ignored for writes.
- `resp_valid` out 1: response beat valid.
- `resp_ready` in 1: response beat consumed.
- `resp_data` out 32: read data; 0 for writes.
- `resp_err` out 1: the APB transfer for this beat returned `pslverr` (or timed out).
- `resp_last` out 1: final beat of the request.
- `out_paddr` out 32, `out_psel` out 1, `out_penable` out 1, `out_pprot` out 3, `out_pwrite` out 1, `out_pwdata` out 32, `out_pstrb` out 4: APB request signals.
- `out_pready` in 1, `out_prdata` in 32, `out_pslverr` in 1: APB completion signals.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On handshake, capture addr (word-aligned), write, wdata, wstrb, and beat counter = `req_len` (0 for writes); go to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0.
  - `paddr`, `pwrite`, `pwdata`, `pstrb` come from registers; `pstrb`=0 on reads.
  - Next cycle: ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1, all APB outputs held stable.
  - When `pready`=1: register `prdata` (reads) and `pslverr` into the response registers, then go to RESP.
- **RESP**
  - `resp_valid`=1; `resp_last`=1 when the counter is 0.
  - On `resp_ready`: if last, go to IDLE. Otherwise decrement the counter, addr += 4, go to SETUP.
- Address increment wraps modulo 2^32; no 4 KB boundary check.
- An error does not abort a burst; the remaining beats still execute, and each reports its own `resp_err`.
- Reset (any state, asynchronous):
  - State = IDLE.
  - `req_ready`=0 while `resetn`=0, 1 after release.
  - All other outputs 0; the counter and registers clear.
  - An in-flight APB transfer is abandoned (`psel` drops immediately).

## Timing
- Request to first APB SETUP: 1 cycle after the `req` handshake.
- Per beat: SETUP 1 cycle, ACCESS ≥1 cycle (until `pready`), RESP ≥1 cycle.
  - Minimum 3 cycles/beat with `pready` and `resp_ready` tied high.
  - The next request is accepted in the cycle after the last response handshake.
- All outputs are registered or decoded from state only; no combinational path from `out_pready`/`out_prdata` to the `resp_*` outputs.
- `req_ready` is low from the accept cycle until the state returns to IDLE.
- `resp_*` hold stable while `resp_valid && !resp_ready`.

## Configuration
- **`SBUS2APB_TIMEOUT_EN` defined:**
  - A counter runs in ACCESS.
  - If `pready` is still low after `TIMEOUT_CYC` cycles, `psel`/`penable` drop and the state goes to RESP with `resp_err`=1 and `resp_data`=32'hDEAD_BEEF.
  - The counter clears on entry to SETUP.
- **Undefined:** ACCESS waits for `pready` indefinitely and no counter logic is generated.

## Test plan
- **Single read:** addr 0x3000_0004, len 0; slave returns 0x1234_5678 with 2 wait states.
  - One SETUP, `penable` high 3 cycles, `paddr`=0x3000_0004.
  - `resp_data`=0x1234_5678, `resp_last`=1, `resp_err`=0.
- **Burst read:** addr 0x3000_0010, len 3; zero-wait slave; `resp_ready` high.
  - `paddr` sequence 0x10, 0x14, 0x18, 0x1C (base 0x3000_0000).
  - 12 cycles from the first SETUP to the last response; `resp_last` only on beat 4.
- **Write:** addr 0x1000_0003, wdata 0xA5A5_A5A5, wstrb 4'b0010.
  - `paddr`=0x1000_0000, `pwrite`=1, `pstrb`=4'b0010.
  - Response `resp_data`=0, `resp_err`=0.
- **Error and backpressure:** 2-beat burst, `pslverr` on beat 1, `resp_ready` held low 5 cycles.
  - Beat 1 `resp_err`=1 and the response stays stable.
  - Beat 2 still issued after the handshake with `resp_err`=0.
- **Reset in ACCESS:** assert `resetn`=0 mid-burst.
  - `psel`/`penable`/`resp_valid` go to 0 asynchronously.
  - After release, `req_ready`=1 and a new read completes normally.
- **Timeout (`SBUS2APB_TIMEOUT_EN`, `TIMEOUT_CYC`=8):** `pready` never asserts.
  - `psel` drops after 8 ACCESS cycles.
  - `resp_err`=1, `resp_data`=0xDEAD_BEEF.
